// File: rtl/rv32_bus_pkg.sv
// Shared definitions for the RV32 data-memory bus: responder FSM states, bus widths
// and the captured request record.
package rv32_bus_pkg;

   localparam int XLEN   = 32;
   localparam int STRB_W = 4;
   localparam int LAT_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0]   addr;
      logic              we;
      logic [STRB_W-1:0] wstrb;
      logic [XLEN-1:0]   wdata;
   } mem_req_t;

endpackage

// File: rtl/dmem_sram.sv
// Word-addressed data array with four byte-lane write enables; write at the rising edge,
// combinational read of the indexed word, no backpressure. Contents survive reset.
module dmem_sram
   import rv32_bus_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [STRB_W-1:0] wstrb,
   input  logic [AW-1:0]     idx,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   rdata
);

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: response valid LATENCY+1 edges after acceptance,
// req_ready low from acceptance until the response handshake; rsp_ready low stalls RESP.
module dmem_responder
   import rv32_bus_pkg::*;
#(
   parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_1000,
   parameter int              DEPTH_WORDS = 1024,
   parameter int              LATENCY     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [XLEN-1:0]   req_addr,
   input  logic              req_we,
   input  logic [STRB_W-1:0] req_wstrb,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err
);

   localparam int               AW       = $clog2(DEPTH_WORDS);
   localparam logic [XLEN:0]    SPAN     = (XLEN+1)'(DEPTH_WORDS) << 2;
   localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

   state_t           state, state_nxt;
   logic [LAT_W-1:0] cnt, cnt_nxt;
   mem_req_t         req_in, cap, cur;
   logic [XLEN-1:0]  offset;
   logic             acc_err;
   logic             enter_resp;
   logic             sram_we;
   logic [XLEN-1:0]  sram_rdata;

   assign req_in = '{addr: req_addr, we: req_we, wstrb: req_wstrb, wdata: req_wdata};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_ready = 1'b0;
      case (state)
         IDLE: begin
            req_ready = reset;
            if (req_valid && reset) begin
               if (LATENCY > 0) begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_INIT;
               end else begin
                  state_nxt = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) state_nxt = RESP;
            else           cnt_nxt   = cnt - LAT_W'(1);
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // With zero latency the access executes on the acceptance edge, before the capture
   // register holds the request, so the live bus is used while still in IDLE.
   assign cur        = (state == IDLE) ? req_in : cap;
   assign enter_resp = (state != RESP) && (state_nxt == RESP);

   assign offset  = cur.addr - BASE_ADDR;
   assign acc_err = (cur.addr[1:0] != 2'b00) || (cur.addr < BASE_ADDR) ||
                    ({1'b0, offset} >= SPAN);
   assign sram_we = enter_resp && reset && cur.we && !acc_err;

   dmem_sram #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_sram (
      .clk  (clk),
      .we   (sram_we),
      .wstrb(cur.wstrb),
      .idx  (offset[AW+1:2]),
      .wdata(cur.wdata),
      .rdata(sram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (enter_resp) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || cur.we) ? '0 : sram_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid && reset) cap <= req_in;
   end

   assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random transactions against a word-array model,
// on a LATENCY=2 instance and a LATENCY=0 instance sharing the request bus.
module tb_dmem_responder;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] req_addr, req_wdata;
   logic        req_we;
   logic [3:0]  req_wstrb;
   logic        v2, v0, rr2, rr0;
   logic        rdy2, rdy0, rv2, rv0, err2, err0;
   logic [31:0] rd2, rd0;

   dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut (
      .clk(clk), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_addr(req_addr),
      .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata), .rsp_valid(rv2),
      .rsp_ready(rr2), .rsp_rdata(rd2), .rsp_err(err2));

   dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
      .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_addr(req_addr),
      .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata), .rsp_valid(rv0),
      .rsp_ready(rr0), .rsp_rdata(rd0), .rsp_err(err0));

   int checks = 0;
   int errors = 0;

   bit          sel;
   logic        c_rdy, c_rv, c_err;
   logic [31:0] c_rd;
   assign c_rdy = sel ? rdy0 : rdy2;
   assign c_rv  = sel ? rv0  : rv2;
   assign c_err = sel ? err0 : err2;
   assign c_rd  = sel ? rd0  : rd2;

   logic [31:0] mem_m [2][DEPTH];
   bit          known [2][DEPTH];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic set_valid(input logic b);
      if (sel) v0 = b; else v2 = b;
   endtask

   task automatic set_rready(input logic b);
      if (sel) rr0 = b; else rr2 = b;
   endtask

   function automatic bit addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'(4 * DEPTH));
   endfunction

   // One complete transaction; entered and left just after a falling edge.
   task automatic txn(input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, input int stall);
      int          k, lat, wi;
      bit          bad, chk_data;
      logic [31:0] exp_d;
      lat = sel ? 0 : 2;
      req_addr = a; req_we = w; req_wstrb = s; req_wdata = d;
      set_valid(1'b1);
      k = 0;
      while (!c_rdy && k < 40) begin @(negedge clk); k++; end
      chk("accept_timeout", 32'(k < 40), 32'd1);
      @(posedge clk);
      bad      = addr_bad(a);
      wi       = int'((a - BASE) >> 2);
      exp_d    = 32'h0;
      chk_data = 1'b1;
      if (!bad && w) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) mem_m[sel][wi][8*b +: 8] = d[8*b +: 8];
         if (s == 4'hF) known[sel][wi] = 1'b1;
      end else if (!bad) begin
         exp_d    = mem_m[sel][wi];
         chk_data = known[sel][wi];
      end
      @(negedge clk);
      k = 1;
      while (!c_rv && k < 40) begin
         set_valid(1'($urandom));
         @(negedge clk);
         k++;
      end
      chk("latency", 32'(k), 32'(lat + 1));
      chk("rsp_err", 32'(c_err), 32'(bad));
      if (chk_data) chk("rsp_rdata", c_rd, exp_d);
      for (int i = 0; i < stall; i++) begin
         set_valid(1'($urandom));
         @(negedge clk);
         chk("stall_valid", 32'(c_rv), 32'd1);
         chk("stall_ready", 32'(c_rdy), 32'd0);
         if (chk_data) chk("stall_rdata", c_rd, exp_d);
      end
      set_rready(1'b1);
      @(posedge clk);
      @(negedge clk);
      set_rready(1'b0);
      set_valid(1'b0);
      chk("ready_after_rsp", 32'(c_rdy), 32'd1);
      chk("valid_after_rsp", 32'(c_rv), 32'd0);
   endtask

   // Store interrupted by reset 'delay' cycles into its wait; nothing may be committed.
   task automatic aborted_store(input logic [31:0] a, input logic [31:0] d, input int delay);
      req_addr = a; req_we = 1'b1; req_wstrb = 4'hF; req_wdata = d;
      v2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v2 = 1'b0;
      repeat (delay) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_valid", 32'(rv2), 32'd0);
      chk("abort_ready", 32'(rdy2), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ready_after", 32'(rdy2), 32'd1);
      chk("abort_valid_after", 32'(rv2), 32'd0);
   endtask

   initial begin
      sel = 1'b0;
      reset = 1'b0; v2 = 1'b1; v0 = 1'b1; rr2 = 1'b0; rr0 = 1'b0;
      req_addr = BASE; req_we = 1'b0; req_wstrb = 4'h0; req_wdata = 32'h0;
      for (int i = 0; i < DEPTH; i++) begin known[0][i] = 1'b0; known[1][i] = 1'b0; end

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_ready", 32'(rdy2), 32'd0);
         chk("rst_valid", 32'(rv2), 32'd0);
         chk("rst_ready_l0", 32'(rdy0), 32'd0);
      end
      chk("rst_err", 32'(err2), 32'd0);
      chk("rst_rdata", rd2, 32'd0);
      v2 = 1'b0; v0 = 1'b0;
      reset = 1'b1;
      #1;
      chk("ready_after_rst", 32'(rdy2), 32'd1);
      @(negedge clk);

      txn(BASE,             1'b1, 4'hF, 32'h0BAD_0000, 0);
      txn(BASE + 32'hFFC,   1'b1, 4'hF, 32'h1111_2222, 0);
      txn(BASE + 32'h8,     1'b1, 4'hF, 32'hCAFE_F00D, 0);
      txn(BASE + 32'h4,     1'b1, 4'hF, 32'hDEAD_BEEF, 0);
      txn(BASE + 32'h4,     1'b0, 4'h0, 32'h0,         0);
      chk("dir_deadbeef", mem_m[0][1], 32'hDEAD_BEEF);
      txn(BASE + 32'h4,     1'b1, 4'h1, 32'h0000_00AA, 0);
      txn(BASE + 32'h4,     1'b0, 4'h0, 32'h0,         0);
      txn(BASE + 32'h4,     1'b1, 4'h0, 32'h5555_5555, 0);
      txn(BASE + 32'h4,     1'b0, 4'h0, 32'h0,         0);
      txn(32'h0000_1002,    1'b0, 4'h0, 32'h0,         0);
      txn(32'h0000_0FFC,    1'b0, 4'h0, 32'h0,         0);
      txn(32'h0000_2000,    1'b0, 4'h0, 32'h0,         0);
      txn(32'h0000_2000,    1'b1, 4'hF, 32'h7777_7777, 0);
      txn(BASE,             1'b0, 4'h0, 32'h0,         0);
      txn(BASE + 32'hFFC,   1'b0, 4'h0, 32'h0,         0);
      txn(BASE + 32'h4,     1'b0, 4'h0, 32'h0,         5);

      aborted_store(BASE + 32'h8, 32'h1234_5678, 0);
      txn(BASE + 32'h8,     1'b0, 4'h0, 32'h0,         0);
      aborted_store(BASE + 32'h8, 32'h1234_5678, 1);
      txn(BASE + 32'h8,     1'b0, 4'h0, 32'h0,         0);

      for (int i = 0; i < 8; i++)
         txn(BASE + 32'(4 * i), 1'b1, 4'hF, $urandom, 0);
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         case ($urandom_range(0, 9))
            0:       a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
            1:       a = BASE - 32'(4 * $urandom_range(1, 4));
            2:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
            default: a = BASE + 32'(4 * $urandom_range(0, 7));
         endcase
         txn(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 3));
      end

      sel = 1'b1;
      txn(BASE + 32'h10, 1'b1, 4'hF, 32'hA5A5_0F0F, 0);
      txn(BASE + 32'h10, 1'b0, 4'h0, 32'h0,         0);
      txn(BASE + 32'h10, 1'b1, 4'h6, 32'h00C3_3C00, 2);
      txn(BASE + 32'h10, 1'b0, 4'h0, 32'h0,         1);
      txn(32'h0000_1011, 1'b0, 4'h0, 32'h0,         0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
